// File: rtl/pc_pkg.sv
// Shared types and defaults for the program-counter unit: redirect-source
// encoding, default step/reset vector, and an alignment helper.
package pc_pkg;

    typedef enum logic [2:0] {
        SRC_SEQ   = 3'd0,
        SRC_STALL = 3'd1,
        SRC_JMP   = 3'd2,
        SRC_RET   = 3'd3,
        SRC_TRAP  = 3'd4,
        SRC_TRET  = 3'd5
    } redirect_src_e;

    localparam int unsigned DEF_STEP    = 32'd4;
    localparam logic [31:0] DEF_RST_VEC = 32'h0000_0000;

    // True when an address is not word aligned.
    function automatic logic low_bits_set(input logic [1:0] addr_lo);
        return (addr_lo != 2'b00);
    endfunction

endpackage

// File: rtl/pc_unit_ras_stack.sv
// Circular return-address stack: pushes overwrite the oldest entry once full,
// the count saturates at RAS_DEPTH, and swap replaces the top in place.
module ras_stack #(
    parameter int XLEN      = 32,
    parameter int RAS_DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            push,
    input  logic            pop,
    input  logic            swap,
    input  logic [XLEN-1:0] data,
    output logic [XLEN-1:0] top,
    output logic            empty,
    output logic            full
);

    localparam int PTR_W = $clog2(RAS_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(RAS_DEPTH);

    logic [XLEN-1:0]  entry_r [RAS_DEPTH];
    logic [PTR_W-1:0] ptr_r;
    logic [CNT_W-1:0] count_r;
    logic [PTR_W-1:0] top_idx_s;
    logic             empty_s;
    logic             full_s;

    // ptr_r names the next free slot; the top lives just below it, modulo depth.
    assign top_idx_s = ptr_r - PTR_W'(1);
    assign empty_s   = (count_r == CNT_W'(0));
    assign full_s    = (count_r == DEPTH_C);
    assign top       = entry_r[top_idx_s];
    assign empty     = empty_s;
    assign full      = full_s;

    // Pointer and saturating occupancy count.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_r   <= PTR_W'(0);
            count_r <= CNT_W'(0);
        end else if (push) begin
            ptr_r <= ptr_r + PTR_W'(1);
            if (!full_s) begin
                count_r <= count_r + CNT_W'(1);
            end
        end else if (pop && !empty_s) begin
            ptr_r   <= top_idx_s;
            count_r <= count_r - CNT_W'(1);
        end
    end

    // Entry storage; contents are don't-care after reset, so no reset term.
    always_ff @(posedge clk) begin
        if (push) begin
            entry_r[ptr_r] <= data;
        end else if (swap && !empty_s) begin
            entry_r[top_idx_s] <= data;
        end
    end

endmodule

// File: rtl/pc_unit.sv
// Fetch program counter: sequential advance, jumps, call/ret through a small
// circular RAS, and single-level trap entry/return with a saved exception PC.
module pc_unit
    import pc_pkg::*;
#(
    parameter int              XLEN      = 32,
    parameter int unsigned     STEP      = DEF_STEP,
    parameter logic [XLEN-1:0] RST_VEC   = XLEN'(DEF_RST_VEC),
    parameter int              RAS_DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall,
    input  logic            jmp,
    input  logic            rel,
    input  logic [XLEN-1:0] nxt,
    input  logic            call,
    input  logic            ret,
    input  logic            trap,
    input  logic [XLEN-1:0] trap_vec,
    input  logic            tret,
    output logic [XLEN-1:0] cur,
    output logic [XLEN-1:0] epc,
    output logic            in_trap,
    output logic            ras_err,
    output logic            misalign
);

    logic [XLEN-1:0] cur_r;
    logic [XLEN-1:0] epc_r;
    logic            in_trap_r;
    logic            ras_err_r;
    logic            misalign_r;

    redirect_src_e   src_s;
    logic [XLEN-1:0] seq_s;
    logic [XLEN-1:0] dest_s;
    logic            redirect_s;
    logic [XLEN-1:0] epc_d_s;
    logic            in_trap_d_s;
    logic            ras_err_d_s;
    logic [XLEN-1:0] cur_d_s;
    logic            misalign_d_s;
    logic            push_s;
    logic            pop_s;
    logic            swap_s;
    logic [XLEN-1:0] ras_top_s;
    logic            ras_empty_s;

    assign seq_s = cur_r + XLEN'(STEP);

    ras_stack #(
        .XLEN      (XLEN),
        .RAS_DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk   (clk),
        .rst   (rst),
        .push  (push_s),
        .pop   (pop_s),
        .swap  (swap_s),
        .data  (seq_s),
        .top   (ras_top_s),
        .empty (ras_empty_s),
        .full  ()
    );

    // Priority select; tret outside a handler falls through to lower sources.
    always_comb begin
        src_s = SRC_SEQ;
        if (trap) begin
            src_s = SRC_TRAP;
        end else if (tret && in_trap_r) begin
            src_s = SRC_TRET;
        end else if (ret) begin
            src_s = SRC_RET;
        end else if (jmp) begin
            src_s = SRC_JMP;
        end else if (stall) begin
            src_s = SRC_STALL;
        end else begin
            src_s = SRC_SEQ;
        end
    end

    // Destination, trap state and RAS control for the selected source.
    always_comb begin
        dest_s      = seq_s;
        redirect_s  = 1'b0;
        epc_d_s     = epc_r;
        in_trap_d_s = in_trap_r;
        ras_err_d_s = 1'b0;
        push_s      = 1'b0;
        pop_s       = 1'b0;
        swap_s      = 1'b0;
        case (src_s)
            SRC_TRAP: begin
                dest_s      = trap_vec;
                redirect_s  = 1'b1;
                epc_d_s     = cur_r;
                in_trap_d_s = 1'b1;
            end
            SRC_TRET: begin
                dest_s      = epc_r;
                redirect_s  = 1'b1;
                in_trap_d_s = 1'b0;
            end
            SRC_RET: begin
                // An empty stack degrades to a plain increment, ignoring stall.
                if (ras_empty_s) begin
                    ras_err_d_s = 1'b1;
                    dest_s      = seq_s;
                end else begin
                    dest_s     = ras_top_s;
                    redirect_s = 1'b1;
                    swap_s     = call;
                    pop_s      = !call;
                end
            end
            SRC_JMP: begin
                dest_s     = rel ? (cur_r + nxt) : nxt;
                redirect_s = 1'b1;
                push_s     = call;
            end
            SRC_STALL: begin
                dest_s = cur_r;
            end
            SRC_SEQ: begin
                dest_s = seq_s;
            end
            default: begin
                dest_s = seq_s;
            end
        endcase
    end

    // Redirect targets are forced to word alignment and flagged.
    always_comb begin
        cur_d_s      = dest_s;
        misalign_d_s = 1'b0;
        if (redirect_s && low_bits_set(dest_s[1:0])) begin
            cur_d_s      = {dest_s[XLEN-1:2], 2'b00};
            misalign_d_s = 1'b1;
        end else begin
            cur_d_s      = dest_s;
            misalign_d_s = 1'b0;
        end
    end

    // Architectural PC state and one-cycle status pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            cur_r      <= RST_VEC;
            epc_r      <= XLEN'(0);
            in_trap_r  <= 1'b0;
            ras_err_r  <= 1'b0;
            misalign_r <= 1'b0;
        end else begin
            cur_r      <= cur_d_s;
            epc_r      <= epc_d_s;
            in_trap_r  <= in_trap_d_s;
            ras_err_r  <= ras_err_d_s;
            misalign_r <= misalign_d_s;
        end
    end

    assign cur      = cur_r;
    assign epc      = epc_r;
    assign in_trap  = in_trap_r;
    assign ras_err  = ras_err_r;
    assign misalign = misalign_r;

endmodule
